// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline boundary: registered {pc, instr} handoff to decode over valid/ready,
// with a 2-entry skid buffer so if_ready never depends combinationally on id_ready.
module if_id_pipe_reg #(
    parameter int unsigned              ADDR_W    = 64,
    parameter int unsigned              INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]       NOP_INSTR = INSTR_W'('h0000_0013),
    parameter int unsigned              CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid,
    input  logic [ADDR_W-1:0]   if_pc,
    input  logic [INSTR_W-1:0]  if_instr,
    output logic                if_ready,
    input  logic                flush,
    output logic                id_valid,
    output logic [ADDR_W-1:0]   id_pc,
    output logic [INSTR_W-1:0]  id_instr,
    output logic                id_illegal,
    input  logic                id_ready,
    output logic [CNT_W-1:0]    stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic                 main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic                 if_ready_q, if_ready_d;
    logic                 id_valid_q, id_valid_d;
    logic [CNT_W-1:0]     stall_q, stall_d;

    logic accept, consume, in_ill;

    assign accept  = if_valid & if_ready_q;
    assign consume = id_valid_q & id_ready;
    assign in_ill  = (if_instr[1:0] != 2'b11);

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        main_ill_d   = main_ill_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_ill_d   = skid_ill_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_FULL;
                    main_pc_d    = if_pc;
                    main_instr_d = if_instr;
                    main_ill_d   = in_ill;
                end
            end
            ST_FULL: begin
                if (accept && consume) begin
                    main_pc_d    = if_pc;
                    main_instr_d = if_instr;
                    main_ill_d   = in_ill;
                end else if (accept) begin
                    state_d      = ST_SKID;
                    skid_pc_d    = if_pc;
                    skid_instr_d = if_instr;
                    skid_ill_d   = in_ill;
                end else if (consume) begin
                    // id_pc keeps the last head; instr/illegal fall back to idle values
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_ill_d   = 1'b0;
                end
            end
            ST_SKID: begin
                if (consume) begin
                    state_d      = ST_FULL;
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                    main_ill_d   = skid_ill_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_ill_d   = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
            skid_ill_d   = 1'b0;
        end
    end

    always_comb begin
        if_ready_d = (state_d != ST_SKID);
        id_valid_d = (state_d != ST_EMPTY);
        stall_d    = stall_q;
        if (id_valid_q && !id_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            main_ill_q   <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_ill_q   <= 1'b0;
            if_ready_q   <= 1'b1;
            id_valid_q   <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            main_ill_q   <= main_ill_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_ill_q   <= skid_ill_d;
            if_ready_q   <= if_ready_d;
            id_valid_q   <= id_valid_d;
            stall_q      <= stall_d;
        end
    end

    assign if_ready     = if_ready_q;
    assign id_valid     = id_valid_q;
    assign id_pc        = main_pc_q;
    assign id_instr     = main_instr_q;
    assign id_illegal   = main_ill_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_if_id_pipe_reg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                if_valid = 1'b0;
    logic [ADDR_W-1:0]   if_pc = '0;
    logic [INSTR_W-1:0]  if_instr = '0;
    logic                if_ready;
    logic                flush = 1'b0;
    logic                id_valid;
    logic [ADDR_W-1:0]   id_pc;
    logic [INSTR_W-1:0]  id_instr;
    logic                id_illegal;
    logic                id_ready = 1'b0;
    logic [CNT_W-1:0]    stall_cycles;

    int checks = 0;
    int errors = 0;

    if_id_pipe_reg #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_illegal(id_illegal),
        .id_ready(id_ready), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // Reference: a FIFO of at most two entries; the head is what decode sees.
    entry_t             mq[$];
    int                 m_stall = 0;
    logic [ADDR_W-1:0]  m_last_pc = '0;
    bit                 m_had, m_room;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_stall   = 0;
            m_last_pc = '0;
        end else begin
            m_had  = (mq.size() > 0);
            m_room = (mq.size() < 2);
            if (m_had && !id_ready && m_stall < 65535) m_stall = m_stall + 1;
            if (flush) mq.delete();
            else begin
                if (m_had && id_ready) void'(mq.pop_front());
                if (if_valid && m_room) mq.push_back('{pc: if_pc, instr: if_instr});
            end
            if (mq.size() > 0) m_last_pc = mq[0].pc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic               e_valid;
        logic [INSTR_W-1:0] e_instr;
        e_valid = (mq.size() > 0);
        e_instr = e_valid ? mq[0].instr : NOP;
        chk("mdl_id_valid",   64'(id_valid),     64'(e_valid));
        chk("mdl_id_pc",      id_pc,             e_valid ? mq[0].pc : m_last_pc);
        chk("mdl_id_instr",   64'(id_instr),     64'(e_instr));
        chk("mdl_id_illegal", 64'(id_illegal),   64'(e_valid && (e_instr[1:0] != 2'b11)));
        chk("mdl_if_ready",   64'(if_ready),     64'(mq.size() < 2));
        chk("mdl_stall",      64'(stall_cycles), 64'(m_stall));
    end

    task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
        @(negedge clk);
        if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins_of(input int i);
        return 32'h0010_0093 + (32'(i) << 20);
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'(NOP));
        chk("rst_stall",    64'(stall_cycles), 64'd0);
        reset = 1'b0;

        // streaming with decode always ready
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 64'(4 * i), ins_of(i), 1'b1, 1'b0);
            chk("str_id_pc",    id_pc, 64'(4 * i));
            chk("str_id_instr", 64'(id_instr), 64'(ins_of(i)));
            chk("str_if_ready", 64'(if_ready), 64'd1);
        end
        cyc(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        chk("str_drain_valid", 64'(id_valid), 64'd0);
        chk("str_stall",       64'(stall_cycles), 64'd0);

        // backpressure into the skid entry, then in-order release
        cyc(1'b1, 64'h10, ins_of(16), 1'b0, 1'b0);
        chk("bp_pc_a",  id_pc, 64'h10);
        chk("bp_rdy_a", 64'(if_ready), 64'd1);
        cyc(1'b1, 64'h14, ins_of(20), 1'b0, 1'b0);
        chk("bp_pc_b",  id_pc, 64'h10);
        chk("bp_rdy_b", 64'(if_ready), 64'd0);
        cyc(1'b1, 64'h18, ins_of(24), 1'b0, 1'b0);
        chk("bp_pc_c",  id_pc, 64'h10);
        chk("bp_rdy_c", 64'(if_ready), 64'd0);
        cyc(1'b1, 64'h18, ins_of(24), 1'b1, 1'b0);
        chk("bp_rel_1", id_pc, 64'h14);
        chk("bp_rdy_d", 64'(if_ready), 64'd1);
        cyc(1'b1, 64'h18, ins_of(24), 1'b1, 1'b0);
        chk("bp_rel_2", id_pc, 64'h18);
        cyc(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        chk("bp_empty", 64'(id_valid), 64'd0);
        chk("bp_stall", 64'(stall_cycles), 64'd2);

        // flush while the skid entry is occupied and a new entry is offered
        cyc(1'b1, 64'h30, ins_of(48), 1'b0, 1'b0);
        cyc(1'b1, 64'h34, ins_of(52), 1'b0, 1'b0);
        chk("fl_pre_rdy", 64'(if_ready), 64'd0);
        cyc(1'b1, 64'h40, ins_of(64), 1'b0, 1'b1);
        chk("fl_valid", 64'(id_valid), 64'd0);
        chk("fl_instr", 64'(id_instr), 64'h13);
        chk("fl_rdy",   64'(if_ready), 64'd1);
        chk("fl_pc",    id_pc, 64'h30);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
            chk("fl_no40", 64'(id_pc == 64'h40), 64'd0);
        end
        chk("fl_stall", 64'(stall_cycles), 64'd4);

        // illegal-encoding flag
        cyc(1'b1, 64'h50, 32'h0000_4501, 1'b1, 1'b0);
        chk("ill_set", 64'(id_illegal), 64'd1);
        cyc(1'b1, 64'h54, 32'h0050_0093, 1'b1, 1'b0);
        chk("ill_clr", 64'(id_illegal), 64'd0);
        cyc(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

        // stall counter saturation; flush leaves it alone
        cyc(1'b1, 64'h70, ins_of(7), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
        chk("sat_stall", 64'(stall_cycles), 64'hFFFF);
        cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
        chk("sat_flush_valid", 64'(id_valid), 64'd0);
        chk("sat_flush_stall", 64'(stall_cycles), 64'hFFFF);

        // asynchronous reset while in the skid state
        cyc(1'b1, 64'h60, ins_of(6), 1'b0, 1'b0);
        cyc(1'b1, 64'h64, ins_of(9), 1'b0, 1'b0);
        chk("ar_pre_rdy", 64'(if_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(id_valid), 64'd0);
        chk("ar_rdy",   64'(if_ready), 64'd1);
        chk("ar_instr", 64'(id_instr), 64'(NOP));
        chk("ar_pc",    id_pc, 64'd0);
        chk("ar_ill",   64'(id_illegal), 64'd0);
        chk("ar_stall", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        if_valid = 1'b0; flush = 1'b0;

        cyc(1'b1, 64'h80, ins_of(3), 1'b1, 1'b0);
        chk("post_pc", id_pc, 64'h80);
        cyc(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        chk("post_valid", 64'(id_valid), 64'd0);
        chk("post_stall", 64'(stall_cycles), 64'd0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
